mem2axi: RTL

MEM2AXI -- requirements
Module: mem2axi

---
 rtl/mem2axi_if.sv | 74 +++++++
 rtl/mem2axi.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem2axi_if.sv
// -----------------------------------------------------------------------------
// axi_if : single-beat AXI4 channel bundle used by mem2axi.
//   Carries the AW, W, B, AR and R channels.
//   Modport m : the master side (drives VALIDs on AW/W/AR and READYs on B/R).
//   Modport s : the slave side (mirror of m).
// Only the fields the bridge needs are present: no RESP/LAST on B/R.
// -----------------------------------------------------------------------------
interface axi_if #(
  parameter int ID_W_WIDTH = 4,
  parameter int ID_R_WIDTH = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
);
  localparam int STRB_WIDTH = DATA_WIDTH / BYTE_WIDTH;

  // Write address channel
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [ID_W_WIDTH-1:0] awid;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  // Write data channel
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  // Write response channel
  logic                  bvalid;
  logic                  bready;
  logic [ID_W_WIDTH-1:0] bid;
  // Read address channel
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [ID_R_WIDTH-1:0] arid;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  // Read data channel
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ID_R_WIDTH-1:0] rid;

  modport m (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid,
    output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rid,
    output rready
  );

  modport s (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid,
    input  bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rid,
    input  rready
  );
endinterface

// File: rtl/mem2axi.sv
// -----------------------------------------------------------------------------
// mem2axi : bridges a simple valid/ready memory request port onto single-beat
// AXI4 transactions, one transaction in flight at a time.
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   req_*           : request (we, word address, write data, byte strobes)
//   resp_valid      : one-cycle completion pulse
//   resp_rdata      : read data (held across writes)
//   resp_err        : returned RID/BID differed from the issued ID
//   axi_m           : AXI master port (AW/W/B/AR/R)
// All request/response and AXI outputs are registered.
// -----------------------------------------------------------------------------
module mem2axi #(
  parameter int ID_W_WIDTH = 4,
  parameter int ID_R_WIDTH = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_we,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] req_wstrb,
  output logic                             resp_valid,
  output logic [DATA_WIDTH-1:0]            resp_rdata,
  output logic                             resp_err,
  axi_if.m                                 axi_m
);
  localparam int       STRB_WIDTH = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [2:0] AX_SIZE  = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_SEND = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t                state_r, state_n;
  logic                  aw_done_r, aw_done_n;
  logic                  w_done_r, w_done_n;
  logic [ID_W_WIDTH-1:0] id_cnt_r;
  logic                  ready_r;
  logic                  arvalid_r, rready_r, awvalid_r, wvalid_r, bready_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [STRB_WIDTH-1:0] wstrb_r;
  logic [ID_W_WIDTH-1:0] awid_r;
  logic [ID_R_WIDTH-1:0] arid_r;
  logic                  resp_valid_r, resp_err_r;
  logic [DATA_WIDTH-1:0] resp_rdata_r;
  logic                  accept_s, rd_fire_s, wr_fire_s, aw_hs_s, w_hs_s;

  // State register, per-channel write completion flags and transaction ID counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
      id_cnt_r  <= '0;
    end else begin
      state_r   <= state_n;
      aw_done_r <= aw_done_n;
      w_done_r  <= w_done_n;
      if (accept_s) begin
        id_cnt_r <= id_cnt_r + ID_W_WIDTH'(1);
      end
    end
  end

  // Next-state logic and handshake detection
  always_comb begin
    state_n   = state_r;
    aw_done_n = aw_done_r;
    w_done_n  = w_done_r;
    accept_s  = 1'b0;
    rd_fire_s = 1'b0;
    wr_fire_s = 1'b0;
    aw_hs_s   = awvalid_r && axi_m.awready;
    w_hs_s    = wvalid_r && axi_m.wready;
    case (state_r)
      IDLE: begin
        if (req_valid && ready_r) begin
          accept_s  = 1'b1;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          state_n   = req_we ? WR_SEND : RD_ADDR;
        end else begin
          state_n = IDLE;
        end
      end
      RD_ADDR: begin
        if (arvalid_r && axi_m.arready) begin
          state_n = RD_DATA;
        end else begin
          state_n = RD_ADDR;
        end
      end
      RD_DATA: begin
        if (axi_m.rvalid && rready_r) begin
          rd_fire_s = 1'b1;
          state_n   = IDLE;
        end else begin
          state_n = RD_DATA;
        end
      end
      WR_SEND: begin
        // AW and W complete independently; leave once both are done,
        // including the case where the last one lands this cycle.
        aw_done_n = aw_done_r || aw_hs_s;
        w_done_n  = w_done_r || w_hs_s;
        if (aw_done_n && w_done_n) begin
          state_n = WR_RESP;
        end else begin
          state_n = WR_SEND;
        end
      end
      WR_RESP: begin
        if (axi_m.bvalid && bready_r) begin
          wr_fire_s = 1'b1;
          state_n   = IDLE;
        end else begin
          state_n = WR_RESP;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Handshake outputs registered from the upcoming state so they align with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_r   <= 1'b0;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
    end else begin
      ready_r   <= (state_n == IDLE);
      arvalid_r <= (state_n == RD_ADDR);
      rready_r  <= (state_n == RD_DATA);
      awvalid_r <= (state_n == WR_SEND) && !aw_done_n;
      wvalid_r  <= (state_n == WR_SEND) && !w_done_n;
      bready_r  <= (state_n == WR_RESP);
    end
  end

  // Request capture; these hold the AXI address/data/ID stable until the next acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r  <= '0;
      wdata_r <= '0;
      wstrb_r <= '0;
      awid_r  <= '0;
      arid_r  <= '0;
    end else if (accept_s) begin
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
      wstrb_r <= req_wstrb;
      awid_r  <= id_cnt_r;
      arid_r  <= ID_R_WIDTH'(id_cnt_r);
    end
  end

  // Completion pulse, read data and ID-mismatch flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= '0;
    end else begin
      resp_valid_r <= rd_fire_s || wr_fire_s;
      if (rd_fire_s) begin
        resp_rdata_r <= axi_m.rdata;
        resp_err_r   <= (axi_m.rid != arid_r);
      end else if (wr_fire_s) begin
        resp_err_r   <= (axi_m.bid != awid_r);
      end
    end
  end

  assign req_ready     = ready_r;
  assign resp_valid    = resp_valid_r;
  assign resp_rdata    = resp_rdata_r;
  assign resp_err      = resp_err_r;

  assign axi_m.awvalid = awvalid_r;
  assign axi_m.awaddr  = addr_r;
  assign axi_m.awid    = awid_r;
  assign axi_m.awlen   = 8'd0;
  assign axi_m.awsize  = AX_SIZE;
  assign axi_m.awburst = 2'b01;
  assign axi_m.wvalid  = wvalid_r;
  assign axi_m.wdata   = wdata_r;
  assign axi_m.wstrb   = wstrb_r;
  assign axi_m.wlast   = 1'b1;
  assign axi_m.bready  = bready_r;
  assign axi_m.arvalid = arvalid_r;
  assign axi_m.araddr  = addr_r;
  assign axi_m.arid    = arid_r;
  assign axi_m.arlen   = 8'd0;
  assign axi_m.arsize  = AX_SIZE;
  assign axi_m.arburst = 2'b01;
  assign axi_m.rready  = rready_r;
endmodule
